// File: rtl/rf_scrubber_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rf_scrubber_pkg: scrub FSM states and the SEC-DED (39,32) code     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package rf_scrubber_pkg;

  localparam int SECDED_W  = 39;
  localparam int SECDED_DW = 32;
  localparam int SECDED_PW = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } scrub_state_t;

  // Codeword bit p is Hamming position p; bit 0 holds overall parity.
  // Mask k selects every position whose index has bit k set.
  localparam logic [SECDED_W-1:0] SECDED_M0 = 39'h2AAAAAAAAA;
  localparam logic [SECDED_W-1:0] SECDED_M1 = 39'h4CCCCCCCCC;
  localparam logic [SECDED_W-1:0] SECDED_M2 = 39'h70F0F0F0F0;
  localparam logic [SECDED_W-1:0] SECDED_M3 = 39'h00FF00FF00;
  localparam logic [SECDED_W-1:0] SECDED_M4 = 39'h00FFFF0000;
  localparam logic [SECDED_W-1:0] SECDED_M5 = 39'h7F00000000;

  function automatic logic [SECDED_PW-1:0] secded_syn(input logic [SECDED_W-1:0] cw);
    return {^(cw & SECDED_M5), ^(cw & SECDED_M4), ^(cw & SECDED_M3),
            ^(cw & SECDED_M2), ^(cw & SECDED_M1), ^(cw & SECDED_M0)};
  endfunction

  function automatic logic [SECDED_DW-1:0] secded_data(input logic [SECDED_W-1:0] cw);
    return {cw[38:33], cw[31:17], cw[15:9], cw[7:5], cw[3]};
  endfunction

  function automatic logic [SECDED_W-1:0] secded_enc(input logic [SECDED_DW-1:0] data);
    logic [SECDED_W-1:0]  cw;
    logic [SECDED_PW-1:0] syn;
    cw         = '0;
    cw[38:33]  = data[31:26];
    cw[31:17]  = data[25:11];
    cw[15:9]   = data[10:4];
    cw[7:5]    = data[3:1];
    cw[3]      = data[0];
    syn        = secded_syn(cw);
    cw[1]      = syn[0];
    cw[2]      = syn[1];
    cw[4]      = syn[2];
    cw[8]      = syn[3];
    cw[16]     = syn[4];
    cw[32]     = syn[5];
    cw[0]      = ^cw[SECDED_W-1:1];
    return cw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scrubber_dec.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | secded_dec: combinational SEC-DED decode with re-encoded output    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module secded_dec
  import rf_scrubber_pkg::*;
(
  input  logic [SECDED_W-1:0]  cw_i,
  output logic [SECDED_DW-1:0] data_o,
  output logic                 ce_o,
  output logic                 uce_o,
  output logic [SECDED_W-1:0]  cw_o
);

  logic [SECDED_PW-1:0] syn;
  logic                 par;
  logic [SECDED_W-1:0]  fixed;

  always_comb begin
    syn   = secded_syn(cw_i);
    par   = ^cw_i;
    fixed = cw_i;
    ce_o  = 1'b0;
    uce_o = 1'b0;
    // Odd overall parity means one flip at position syn; a syndrome past
    // the last position can only come from a multi-bit upset.
    if (par) begin
      if (syn < SECDED_PW'(SECDED_W)) begin
        ce_o  = 1'b1;
        fixed = cw_i ^ (SECDED_W'(1) << syn);
      end else begin
        uce_o = 1'b1;
      end
    end else if (syn != '0) begin
      uce_o = 1'b1;
    end
    data_o = secded_data(fixed);
    cw_o   = secded_enc(data_o);
  end

endmodule
`default_nettype wire

// File: rtl/rf_scrubber.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rf_scrubber: background SEC-DED scrubber for the register file     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rf_scrubber
  import rf_scrubber_pkg::*;
#(
  parameter int DW     = SECDED_DW,
  parameter int W      = SECDED_W,
  parameter int N      = 32,
  parameter int ADDW   = $clog2(N),
  parameter int PERIOD = 64,
  parameter int CNTW   = 8
) (
  input  logic            s_clk_i,
  input  logic            s_rst_i,
  input  logic            s_en_i,
  input  logic            s_core_we_i,
  input  logic [ADDW-1:0] s_core_wadd_i,
  output logic [ADDW-1:0] s_radd_o,
  input  logic [W-1:0]    s_rdata_i,
  output logic            s_we_o,
  output logic [ADDW-1:0] s_wadd_o,
  output logic [W-1:0]    s_wval_o,
  output logic            s_ce_o,
  output logic            s_uce_o,
  output logic [ADDW-1:0] s_uce_add_o,
  output logic [CNTW-1:0] s_ce_cnt_o
);

  localparam int              PCW        = $clog2(PERIOD + 1);
  localparam logic [ADDW-1:0] FIRST_ADDR = ADDW'(1);
  localparam logic [ADDW-1:0] LAST_ADDR  = ADDW'(N - 1);
  localparam logic [PCW-1:0]  RELOAD     = PCW'(PERIOD - 1);

  scrub_state_t    state_q, state_d;
  logic [ADDW-1:0] addr_q, addr_d;
  logic [PCW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]    wval_q, wval_d;
  logic            ce_q, ce_d;
  logic            uce_q, uce_d;
  logic [ADDW-1:0] uce_add_q, uce_add_d;
  logic [CNTW-1:0] ce_cnt_q, ce_cnt_d;

  logic [DW-1:0]   dec_data_unused;
  logic            dec_ce;
  logic            dec_uce;
  logic [W-1:0]    dec_cw;
  logic            core_hit;
  logic [ADDW-1:0] addr_inc;

  secded_dec u_dec (
    .cw_i   (s_rdata_i),
    .data_o (dec_data_unused),
    .ce_o   (dec_ce),
    .uce_o  (dec_uce),
    .cw_o   (dec_cw)
  );

  assign core_hit = s_core_we_i && (s_core_wadd_i == addr_q);
  assign addr_inc = (addr_q == LAST_ADDR) ? FIRST_ADDR : addr_q + ADDW'(1);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wval_d    = wval_q;
    ce_d      = 1'b0;
    uce_d     = 1'b0;
    uce_add_d = uce_add_q;
    ce_cnt_d  = ce_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (s_en_i) begin
          if (cnt_q == '0) begin
            state_d = S_READ;
            cnt_d   = RELOAD;
          end else begin
            cnt_d = cnt_q - PCW'(1);
          end
        end
      end
      S_READ: begin
        state_d = S_IDLE;
        addr_d  = addr_inc;
        // A same-cycle core write makes the sampled word stale; drop it.
        if (!core_hit) begin
          if (dec_uce) begin
            uce_d     = 1'b1;
            uce_add_d = addr_q;
          end else if (dec_ce) begin
            ce_d    = 1'b1;
            wval_d  = dec_cw;
            addr_d  = addr_q;
            state_d = S_WRITE;
            if (ce_cnt_q != '1) begin
              ce_cnt_d = ce_cnt_q + CNTW'(1);
            end
          end
        end
      end
      S_WRITE: begin
        // Core owns the port while it writes; its data to our target supersedes ours.
        if (!s_core_we_i || core_hit) begin
          state_d = S_IDLE;
          addr_d  = addr_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= FIRST_ADDR;
      cnt_q     <= RELOAD;
      wval_q    <= '0;
      ce_q      <= 1'b0;
      uce_q     <= 1'b0;
      uce_add_q <= '0;
      ce_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wval_q    <= wval_d;
      ce_q      <= ce_d;
      uce_q     <= uce_d;
      uce_add_q <= uce_add_d;
      ce_cnt_q  <= ce_cnt_d;
    end
  end

  assign s_radd_o    = (state_q == S_READ && !s_rst_i) ? addr_q : '0;
  assign s_we_o      = (state_q == S_WRITE) && !s_core_we_i && !s_rst_i;
  assign s_wadd_o    = (state_q == S_WRITE && !s_rst_i) ? addr_q : '0;
  assign s_wval_o    = (state_q == S_WRITE && !s_rst_i) ? wval_q : '0;
  assign s_ce_o      = ce_q;
  assign s_uce_o     = uce_q;
  assign s_uce_add_o = uce_add_q;
  assign s_ce_cnt_o  = ce_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_scrubber.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rf_scrubber: register-file model plus scan-order reference      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_rf_scrubber;
  import rf_scrubber_pkg::*;

  localparam int N = 32, ADDW = 5, PERIOD = 4, CNTW = 8, W = 39, DW = 32;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic            clk = 1'b0, rst = 1'b1, en = 1'b0, core_we = 1'b0;
  logic [ADDW-1:0] core_wadd = '0;
  logic [W-1:0]    core_val = '0;
  logic [ADDW-1:0] radd, wadd, uce_add;
  logic [W-1:0]    rdata, wval;
  logic            we, ce, uce;
  logic [CNTW-1:0] ce_cnt;
  logic            bd_we = 1'b0;
  logic [ADDW-1:0] bd_addr = '0;
  logic [W-1:0]    bd_val = '0;
  logic [W-1:0]    rf [N];
  int              collisions = 0;

  logic [W-1:0]    golden [N];
  int              flips [N];
  int              nxt, last, cyc, gap_exp, exp_cnt, checks, failures, hold_a;

  rf_scrubber #(.DW(DW), .W(W), .N(N), .ADDW(ADDW), .PERIOD(PERIOD), .CNTW(CNTW)) dut (
    .s_clk_i(clk), .s_rst_i(rst), .s_en_i(en), .s_core_we_i(core_we),
    .s_core_wadd_i(core_wadd), .s_radd_o(radd), .s_rdata_i(rdata), .s_we_o(we),
    .s_wadd_o(wadd), .s_wval_o(wval), .s_ce_o(ce), .s_uce_o(uce),
    .s_uce_add_o(uce_add), .s_ce_cnt_o(ce_cnt)
  );

  always #5 clk = ~clk;
  assign rdata = rf[radd];

  always @(posedge clk) begin
    if (core_we && we) collisions <= collisions + 1;
    if (core_we) rf[core_wadd] <= core_val;
    else if (we) rf[wadd] <= wval;
    if (bd_we) rf[bd_addr] <= bd_val;
  end

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int a, input logic [W-1:0] v);
    bd_we = 1'b1; bd_addr = ADDW'(a); bd_val = v;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic inject_mask(input int a, input logic [W-1:0] m, input int nb);
    poke(a, golden[a] ^ m);
    flips[a] = nb;
  endtask

  task automatic inject_rand(input int a, input int nb);
    logic [W-1:0] m;
    int b0, b1;
    b0 = $urandom_range(0, W - 1);
    b1 = b0;
    while (b1 == b0) b1 = $urandom_range(0, W - 1);
    m = '0;
    m[b0] = 1'b1;
    if (nb == 2) m[b1] = 1'b1;
    inject_mask(a, m, nb);
  endtask

  task automatic adv();
    nxt = (nxt == N - 1) ? 1 : nxt + 1;
  endtask

  task automatic wait_read();
    int n;
    bit quiet;
    n = 0; quiet = 1'b1;
    while (radd == '0 && n < 200) begin
      if (we) quiet = 1'b0;
      tick(); n++;
    end
    chk("idle_no_write", quiet, 1);
    chk("read_addr", radd, nxt);
    chk("read_gap", cyc - last, gap_exp);
    last = cyc;
  endtask

  task automatic scan_step();
    wait_read();
    tick();
    if (flips[nxt] == 0) begin
      chk("clean_flags", {ce, uce, we}, 3'b000);
      gap_exp = PERIOD + 1;
    end else if (flips[nxt] == 1) begin
      exp_cnt = (exp_cnt < CNT_MAX) ? exp_cnt + 1 : CNT_MAX;
      chk("ce_flags", {ce, uce, we}, 3'b101);
      chk("ce_wadd", wadd, nxt);
      chk("ce_wval", wval, golden[nxt]);
      chk("ce_cnt", ce_cnt, exp_cnt);
      tick();
      chk("ce_fixed", rf[nxt], golden[nxt]);
      chk("ce_pulse_end", {ce, we}, 2'b00);
      flips[nxt] = 0;
      gap_exp = PERIOD + 2;
    end else begin
      chk("uce_flags", {ce, uce, we}, 3'b010);
      chk("uce_add", uce_add, nxt);
      gap_exp = PERIOD + 1;
    end
    adv();
  endtask

  task automatic scan_upto(input int a);
    int n;
    n = 0;
    while (nxt != a && n < 64) begin
      scan_step(); n++;
    end
  endtask

  initial begin
    bit quiet;
    cyc = 0; checks = 0; failures = 0;
    for (int i = 0; i < N; i++) begin
      golden[i] = secded_enc($urandom());
      flips[i] = 0;
    end
    tick(); tick();
    for (int i = 0; i < N; i++) poke(i, golden[i]);
    chk("rst_radd", radd, 0);
    chk("rst_we", we, 0);
    chk("rst_wadd", wadd, 0);
    chk("rst_wval", wval, 0);
    chk("rst_flags", {ce, uce}, 2'b00);
    chk("rst_uce_add", uce_add, 0);
    chk("rst_ce_cnt", ce_cnt, 0);

    // Clean sweep including wrap back to x1
    en = 1'b1; rst = 1'b0;
    last = cyc; nxt = 1; gap_exp = PERIOD; exp_cnt = 0;
    repeat (32) scan_step();

    // Single-bit upset in x7, double-bit in x12, random ones elsewhere
    inject_mask(7, 39'd1 << 5, 1);
    scan_upto(8);
    inject_mask(12, (39'd1 << 3) | (39'd1 << 9), 2);
    inject_rand(15, 1);
    inject_rand(18, 2);
    scan_upto(19);

    // Core stalls the correction of x9 with 3 writes to x4
    inject_rand(9, 1);
    scan_upto(9);
    wait_read();
    tick();
    exp_cnt++;
    chk("stall_ce_flags", {ce, uce, we}, 3'b101);
    chk("stall_ce_cnt", ce_cnt, exp_cnt);
    core_val = secded_enc($urandom()); core_wadd = 5'd4; core_we = 1'b1;
    golden[4] = core_val; flips[4] = 0;
    repeat (3) begin
      #1; chk("stall_we_low", we, 0);
      tick();
    end
    core_we = 1'b0;
    #1;
    chk("stall_we_high", we, 1);
    chk("stall_wadd", wadd, 9);
    chk("stall_wval", wval, golden[9]);
    tick();
    chk("stall_fixed", rf[9], golden[9]);
    chk("stall_core_data", rf[4], golden[4]);
    flips[9] = 0; gap_exp = PERIOD + 2 + 3; adv();

    // Core writes the register being corrected: abort
    inject_rand(10, 1);
    wait_read();
    tick();
    exp_cnt++;
    chk("abort_ce_flags", {ce, uce, we}, 3'b101);
    core_val = secded_enc($urandom()); core_wadd = 5'd10; core_we = 1'b1;
    #1; chk("abort_we", we, 0);
    tick();
    core_we = 1'b0;
    golden[10] = core_val; flips[10] = 0;
    chk("abort_wadd_idle", wadd, 0);
    chk("abort_core_wins", rf[10], golden[10]);
    chk("abort_ce_cnt", ce_cnt, exp_cnt);
    gap_exp = PERIOD + 2; adv();

    // Core writes the register being read: result discarded
    inject_rand(11, 1);
    wait_read();
    core_val = secded_enc($urandom()); core_wadd = 5'd11; core_we = 1'b1;
    #1;
    tick();
    core_we = 1'b0;
    golden[11] = core_val; flips[11] = 0;
    chk("rdhit_flags", {ce, uce, we}, 3'b000);
    chk("rdhit_ce_cnt", ce_cnt, exp_cnt);
    chk("rdhit_core_data", rf[11], golden[11]);
    gap_exp = PERIOD + 1; adv();
    scan_step();

    // Counter saturation
    repeat (300) begin
      inject_rand(nxt, 1);
      scan_step();
    end
    chk("ce_cnt_sat", ce_cnt, CNT_MAX);

    // Disable freezes the scan position and period count
    scan_step();
    en = 1'b0; quiet = 1'b1;
    repeat (50) begin
      tick();
      if (radd != '0 || we) quiet = 1'b0;
    end
    chk("disabled_quiet", quiet, 1);
    en = 1'b1;
    gap_exp = PERIOD + 1 + 50;
    scan_step();

    // Reset while a correction write is pending
    hold_a = nxt;
    inject_rand(hold_a, 1);
    wait_read();
    tick();
    chk("prerst_we", we, 1);
    rst = 1'b1;
    #1; chk("rst_cycle_we", we, 0);
    tick();
    chk("rst2_flags", {ce, uce, we}, 3'b000);
    chk("rst2_ce_cnt", ce_cnt, 0);
    chk("rst2_uce_add", uce_add, 0);
    chk("rst2_radd", radd, 0);
    rst = 1'b0;
    chk("rst_dropped_write", rf[hold_a] != golden[hold_a], 1);
    exp_cnt = 0; nxt = 1; last = cyc; gap_exp = PERIOD;
    scan_step();
    scan_step();
    chk("no_port_collision", collisions, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
